// File: rtl/stack_seq_pkg.sv
// Shared types for the stack-path sequencer: op codes, chain states
// and the kind of chain currently running.
package stack_seq_pkg;

   typedef enum logic [1:0] {
      SEQ_CALL = 2'd0,
      SEQ_RET  = 2'd1,
      SEQ_RTI  = 2'd2,
      SEQ_NONE = 2'd3
   } seq_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH_PC,
      S_PUSH_FLAGS,
      S_POP_FLAGS,
      S_POP_PC,
      S_WAIT_PC,
      S_LOAD
   } seq_state_e;

   typedef enum logic [1:0] {
      K_CALL,
      K_RET,
      K_RTI,
      K_INT
   } chain_e;

   function automatic seq_state_e first_state(seq_op_e op);
      unique case (op)
         SEQ_CALL: first_state = S_PUSH_PC;
         SEQ_RET:  first_state = S_POP_PC;
         SEQ_RTI:  first_state = S_POP_FLAGS;
         default:  first_state = S_IDLE;
      endcase
   endfunction

   function automatic chain_e op_kind(seq_op_e op);
      unique case (op)
         SEQ_CALL: op_kind = K_CALL;
         SEQ_RET:  op_kind = K_RET;
         default:  op_kind = K_RTI;
      endcase
   endfunction

endpackage

// File: rtl/stack_sequencer_irq.sv
// Interrupt request latch and global interrupt enable.
// A request is remembered until it is actually taken.
module irq_pending_latch (
   input  logic clk,
   input  logic rst,
   input  logic int_req,
   input  logic take_int,
   input  logic rti_done,
   output logic pending,
   output logic int_en
);

   logic pending_q, pending_d;
   logic int_en_q, int_en_d;

   always_comb begin
      pending_d = (pending_q & ~take_int) | int_req;
      int_en_d  = int_en_q;
      if (take_int) begin
         int_en_d = 1'b0;
      end else if (rti_done) begin
         int_en_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= 1'b0;
         int_en_q  <= 1'b1;
      end else begin
         pending_q <= pending_d;
         int_en_q  <= int_en_d;
      end
   end

   assign pending = pending_q;
   assign int_en  = int_en_q;

endmodule

// File: rtl/stack_sequencer.sv
// Stack-path sequencer: runs CALL/RET/RTI/interrupt micro-op chains
// one state per cycle and redirects fetch at the end of each chain.
module stack_sequencer
   import stack_seq_pkg::*;
#(
   parameter int              PC_W       = 32,
   parameter logic [PC_W-1:0] INT_VECTOR = PC_W'(1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            op_valid,
   input  logic [1:0]      op_code,
   input  logic [PC_W-1:0] call_target,
   input  logic [PC_W-1:0] ret_pc,
   input  logic            int_req,
   input  logic [PC_W-1:0] mem_rdata,
   output logic            seq_sp,
   output logic            seq_spop,
   output logic            seq_stack_pc,
   output logic            seq_stack_flags,
   output logic            seq_mr,
   output logic            seq_mw,
   output logic [PC_W-1:0] push_data,
   output logic            stall_front,
   output logic            pc_load,
   output logic [PC_W-1:0] pc_next,
   output logic            int_en,
   output logic            busy
);

   seq_state_e      state_q, state_d;
   chain_e          kind_q, kind_d;
   logic [PC_W-1:0] ret_pc_q, ret_pc_d;
   logic [PC_W-1:0] target_q, target_d;
   logic [PC_W-1:0] rdata_q, rdata_d;

   seq_op_e op_e;
   logic    idle, accept, take_int, pending, rti_done;

   assign op_e     = seq_op_e'(op_code);
   assign idle     = (state_q == S_IDLE);
   assign accept   = idle & op_valid & (op_e != SEQ_NONE);
   assign take_int = idle & ~accept & pending & int_en;
   assign rti_done = (state_q == S_LOAD) & (kind_q == K_RTI);

   irq_pending_latch u_irq (
      .clk      (clk),
      .rst      (rst),
      .int_req  (int_req),
      .take_int (take_int),
      .rti_done (rti_done),
      .pending  (pending),
      .int_en   (int_en)
   );

   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      ret_pc_d = ret_pc_q;
      target_d = target_q;
      rdata_d  = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d  = first_state(op_e);
               kind_d   = op_kind(op_e);
               ret_pc_d = ret_pc;
               target_d = call_target;
            end else if (take_int) begin
               state_d  = S_PUSH_PC;
               kind_d   = K_INT;
               ret_pc_d = ret_pc;
            end
         end
         S_PUSH_PC:
            state_d = (kind_q == K_INT) ? S_PUSH_FLAGS : S_LOAD;
         S_PUSH_FLAGS: state_d = S_LOAD;
         S_POP_FLAGS:  state_d = S_POP_PC;
         S_POP_PC:     state_d = S_WAIT_PC;
         S_WAIT_PC: begin
            // read data returns the cycle after the MR strobe
            rdata_d = mem_rdata;
            state_d = S_LOAD;
         end
         S_LOAD:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      seq_sp          = 1'b0;
      seq_spop        = 1'b0;
      seq_stack_pc    = 1'b0;
      seq_stack_flags = 1'b0;
      seq_mr          = 1'b0;
      seq_mw          = 1'b0;
      pc_load         = 1'b0;
      pc_next         = '0;
      unique case (state_q)
         S_PUSH_PC: begin
            seq_sp       = 1'b1;
            seq_mw       = 1'b1;
            seq_stack_pc = 1'b1;
         end
         S_PUSH_FLAGS: begin
            seq_sp          = 1'b1;
            seq_mw          = 1'b1;
            seq_stack_flags = 1'b1;
         end
         S_POP_FLAGS: begin
            seq_sp          = 1'b1;
            seq_spop        = 1'b1;
            seq_mr          = 1'b1;
            seq_stack_flags = 1'b1;
         end
         S_POP_PC: begin
            seq_sp       = 1'b1;
            seq_spop     = 1'b1;
            seq_mr       = 1'b1;
            seq_stack_pc = 1'b1;
         end
         S_LOAD: begin
            pc_load = 1'b1;
            unique case (kind_q)
               K_CALL:  pc_next = target_q;
               K_INT:   pc_next = INT_VECTOR;
               default: pc_next = rdata_q;
            endcase
         end
         default: ;
      endcase
   end

   assign busy        = ~idle;
   assign stall_front = busy | accept | take_int;
   assign push_data   = ret_pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         kind_q   <= K_CALL;
         ret_pc_q <= '0;
         target_q <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         kind_q   <= kind_d;
         ret_pc_q <= ret_pc_d;
         target_q <= target_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: a chain-level model queues
// expected strobe events, a negedge monitor pops and compares them.
module tb_stack_sequencer;
   import stack_seq_pkg::*;

   localparam int NCYC = 2400;

   localparam logic [6:0] F_PUSH_PC = 7'b1010010;
   localparam logic [6:0] F_PUSH_FL = 7'b1001010;
   localparam logic [6:0] F_POP_FL  = 7'b1101100;
   localparam logic [6:0] F_POP_PC  = 7'b1110100;
   localparam logic [6:0] F_LOAD    = 7'b0000001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        op_valid = 1'b0;
   logic [1:0]  op_code = 2'd3;
   logic [31:0] call_target = '0;
   logic [31:0] ret_pc = '0;
   logic        int_req = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        seq_sp, seq_spop, seq_stack_pc, seq_stack_flags;
   logic        seq_mr, seq_mw, stall_front, pc_load, int_en, busy;
   logic [31:0] push_data, pc_next;

   always #5 clk = ~clk;

   stack_sequencer #(.PC_W(32), .INT_VECTOR(32'd1)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
      .call_target(call_target), .ret_pc(ret_pc), .int_req(int_req),
      .mem_rdata(mem_rdata), .seq_sp(seq_sp), .seq_spop(seq_spop),
      .seq_stack_pc(seq_stack_pc), .seq_stack_flags(seq_stack_flags),
      .seq_mr(seq_mr), .seq_mw(seq_mw), .push_data(push_data),
      .stall_front(stall_front), .pc_load(pc_load), .pc_next(pc_next),
      .int_en(int_en), .busy(busy)
   );

   typedef struct {
      int          cyc;
      logic [6:0]  flags;
      logic [31:0] pcn;
      logic [31:0] pd;
      bit          chk_pd;
   } ev_t;

   ev_t         evq[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          chk_en = 1'b0;
   bit          exp_stall, exp_busy, exp_ien;
   int          m_busy = 0;
   bit          m_pend = 1'b0;
   bit          m_ien = 1'b1;
   int          m_ien_at = -1;
   logic [31:0] rd_arr[NCYC];

   function automatic void push_ev(int c, logic [6:0] f, logic [31:0] pcn,
                                   logic [31:0] pd, bit chk);
      ev_t e;
      e.cyc = c; e.flags = f; e.pcn = pcn; e.pd = pd; e.chk_pd = chk;
      evq.push_back(e);
   endfunction

   // one clock of stimulus plus the reference model's view of it
   task automatic run_cycle(input bit v, input logic [1:0] code,
                            input logic [31:0] rpc, input logic [31:0] tgt,
                            input bit irq, input bit r, output bit acc);
      bit idle, take;
      @(posedge clk);
      #1;
      cyc++;
      op_valid = v; op_code = code; ret_pc = rpc; call_target = tgt;
      int_req = irq; rst = r; mem_rdata = rd_arr[cyc];
      idle = (m_busy == 0);
      acc  = idle && v && (code != 2'd3);
      take = idle && !acc && m_pend && m_ien;
      exp_stall = !idle || acc || take;
      exp_busy  = !idle;
      exp_ien   = m_ien;
      if (r) begin
         acc = 1'b0;
         m_busy = 0; m_pend = 1'b0; m_ien = 1'b1; m_ien_at = -1;
         for (int i = evq.size() - 1; i >= 0; i--)
            if (evq[i].cyc > cyc) evq.delete(i);
      end else begin
         if (m_busy > 0) m_busy--;
         if (acc) begin
            case (code)
               2'd0: begin
                  push_ev(cyc + 1, F_PUSH_PC, '0, rpc, 1'b1);
                  push_ev(cyc + 2, F_LOAD, tgt, '0, 1'b0);
                  m_busy = 2;
               end
               2'd1: begin
                  push_ev(cyc + 1, F_POP_PC, '0, '0, 1'b0);
                  push_ev(cyc + 3, F_LOAD, rd_arr[cyc + 2], '0, 1'b0);
                  m_busy = 3;
               end
               default: begin
                  push_ev(cyc + 1, F_POP_FL, '0, '0, 1'b0);
                  push_ev(cyc + 2, F_POP_PC, '0, '0, 1'b0);
                  push_ev(cyc + 4, F_LOAD, rd_arr[cyc + 3], '0, 1'b0);
                  m_busy = 4;
                  m_ien_at = cyc + 4;
               end
            endcase
         end
         if (take) begin
            push_ev(cyc + 1, F_PUSH_PC, '0, rpc, 1'b1);
            push_ev(cyc + 2, F_PUSH_FL, '0, '0, 1'b0);
            push_ev(cyc + 3, F_LOAD, 32'd1, '0, 1'b0);
            m_busy = 3;
            m_ien = 1'b0;
         end
         m_pend = (m_pend && !take) || irq;
         if (cyc == m_ien_at) m_ien = 1'b1;
      end
   endtask

   task automatic idle_cycles(input int n);
      bit a;
      for (int i = 0; i < n; i++)
         run_cycle(1'b0, 2'd3, $urandom, $urandom, 1'b0, 1'b0, a);
   endtask

   task automatic check_quiet(input string nm);
      logic [6:0] s;
      @(negedge clk);
      s = {seq_sp, seq_spop, seq_stack_pc, seq_stack_flags,
           seq_mr, seq_mw, pc_load};
      total++;
      if (s !== 7'd0 || pc_next !== 32'd0 || push_data !== 32'd0 ||
          busy !== 1'b0 || int_en !== 1'b1) begin
         bad++;
         $display("FAIL %s strobes=%b pc_next=%h push=%h busy=%b ien=%b want 0/0/0/0/1",
                  nm, s, pc_next, push_data, busy, int_en);
      end
   endtask

   ev_t        me;
   logic [6:0] act;
   bit         ok;

   always @(negedge clk) begin
      if (chk_en) begin
         total++;
         if ({stall_front, busy, int_en} !== {exp_stall, exp_busy, exp_ien}) begin
            bad++;
            $display("FAIL ctl cyc=%0d stall/busy/ien got=%b want=%b", cyc,
                     {stall_front, busy, int_en}, {exp_stall, exp_busy, exp_ien});
         end
         act = {seq_sp, seq_spop, seq_stack_pc, seq_stack_flags,
                seq_mr, seq_mw, pc_load};
         if (act !== 7'd0) begin
            total++;
            if (evq.size() == 0) begin
               bad++;
               $display("FAIL unexpected cyc=%0d strobes=%b want none", cyc, act);
            end else begin
               me = evq.pop_front();
               ok = (me.cyc == cyc) && (act === me.flags) &&
                    (!me.flags[0] || pc_next === me.pcn) &&
                    (!me.chk_pd || push_data === me.pd);
               if (!ok) begin
                  bad++;
                  $display("FAIL ev cyc=%0d got f=%b pc=%h pd=%h want cyc=%0d f=%b pc=%h pd=%h",
                           cyc, act, pc_next, push_data, me.cyc, me.flags, me.pcn, me.pd);
               end
            end
         end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
            total++;
            bad++;
            me = evq.pop_front();
            $display("FAIL missed cyc=%0d got none want f=%b at cyc=%0d",
                     cyc, me.flags, me.cyc);
         end
      end
   end

   initial begin
      bit          a, cv, r, irq;
      logic [1:0]  cc;
      logic [31:0] ct;
      for (int i = 0; i < NCYC; i++) rd_arr[i] = $urandom;

      for (int i = 0; i < 3; i++)
         run_cycle(1'b0, 2'd3, '0, '0, 1'b0, 1'b1, a);
      chk_en = 1'b1;
      idle_cycles(1);
      check_quiet("reset_state");

      run_cycle(1'b1, 2'd0, 32'h10, 32'h40, 1'b0, 1'b0, a);
      idle_cycles(3);

      rd_arr[cyc + 3] = 32'h11;
      run_cycle(1'b1, 2'd1, 32'h14, '0, 1'b0, 1'b0, a);
      idle_cycles(4);

      run_cycle(1'b0, 2'd3, 32'h22, '0, 1'b1, 1'b0, a);
      run_cycle(1'b0, 2'd3, 32'h22, '0, 1'b0, 1'b0, a);
      idle_cycles(4);

      run_cycle(1'b0, 2'd3, 32'h30, '0, 1'b1, 1'b0, a);
      idle_cycles(5);
      run_cycle(1'b1, 2'd2, 32'h34, '0, 1'b0, 1'b0, a);
      idle_cycles(8);
      run_cycle(1'b1, 2'd2, 32'h38, '0, 1'b0, 1'b0, a);
      idle_cycles(6);

      run_cycle(1'b1, 2'd1, 32'h50, '0, 1'b1, 1'b0, a);
      idle_cycles(7);
      run_cycle(1'b1, 2'd2, 32'h54, '0, 1'b0, 1'b0, a);
      idle_cycles(6);

      run_cycle(1'b1, 2'd1, 32'h60, '0, 1'b1, 1'b0, a);
      run_cycle(1'b0, 2'd3, 32'h64, '0, 1'b0, 1'b1, a);
      idle_cycles(1);
      check_quiet("reset_mid_chain");
      idle_cycles(4);

      cv = 1'b0; cc = 2'd3; ct = '0;
      for (int i = 0; i < 2000; i++) begin
         if (!cv && $urandom_range(0, 2) == 0) begin
            cv = 1'b1;
            cc = 2'($urandom_range(0, 3));
            ct = $urandom;
         end
         r   = ($urandom_range(0, 199) == 0);
         irq = !r && ($urandom_range(0, 11) == 0);
         run_cycle(cv && !r, cc, $urandom, ct, irq, r, a);
         if (a || (cv && cc == 2'd3 && !r)) cv = 1'b0;
      end
      idle_cycles(12);

      total++;
      if (evq.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want 0", evq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
